truth_table_sequencer: RTL
==========================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, default 10, clock cycles each input vector is held before the DUT output is sampled (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  one-cycle request to run a full truth-table sweep.
REQ-005 SHALL have port: expect_tt  input  4  expected output per vector; bit i is the expected value for index i = {b,a}.
REQ-006 SHALL have port: dut_out  input  1  output of the 2-input gate under test.
REQ-007 SHALL have port: a  output  1  first gate input, driven to the DUT.
REQ-008 SHALL have port: b  output  1  second gate input, driven to the DUT.
REQ-009 SHALL have port: vec_idx  output  2  index {b,a} of the vector currently applied.
REQ-010 SHALL have port: busy  output  1  high while a sweep is in progress.
REQ-011 SHALL have port: mismatch  output  1  one-cycle pulse when a sampled dut_out differs from expectation.
REQ-012 SHALL have port: err_count  output  3  number of mismatches in the current or last sweep (0..4).
REQ-013 SHALL have port: done  output  1  one-cycle pulse at sweep completion.
REQ-014 SHALL have port: pass  output  1  result of the last completed sweep; high iff err_count == 0.

Function
REQ-015 SHALL implement states IDLE, HOLD, SAMPLE, FINISH.
REQ-016 In IDLE, start=1 SHALL capture expect_tt, set vec_idx=0, a=0, b=0, clear err_count, clear pass, set busy=1, load the hold counter, and enter HOLD on the same edge.
REQ-017 Vector order SHALL be idx 0,1,2,3, i.e. (a,b) = (0,0),(1,0),(0,1),(1,1); a = vec_idx[0], b = vec_idx[1].
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles with a/b stable, then enter SAMPLE.
REQ-019 SAMPLE SHALL last one cycle, compare dut_out against captured expect_tt[vec_idx], and on inequality pulse mismatch for that cycle (registered, visible the next cycle) and increment err_count.
REQ-020 From SAMPLE with vec_idx<3, SHALL increment vec_idx (updating a/b), reload the hold counter, and return to HOLD.
REQ-021 From SAMPLE with vec_idx==3, SHALL enter FINISH; a/b SHALL remain (1,1).
REQ-022 FINISH SHALL last one cycle: done=1, pass=(err_count==0) including any mismatch from the final sample, busy=0 on exit, return to IDLE.
REQ-023 Sweep latency start-edge to done-high SHALL be exactly 4*(HOLD_CYCLES+1)+1 cycles.
REQ-024 start while busy=1 SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-025 expect_tt changes during a sweep SHALL have no effect (captured copy only).
REQ-026 err_count SHALL saturate at 4 and never wrap.
REQ-027 err_count, pass and vec_idx SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, a=0, b=0, vec_idx=0, busy=0, mismatch=0, err_count=0, done=0, pass=0, regardless of state.
REQ-029 Deassertion of rst mid-sweep SHALL NOT resume the sweep; a new start is required.

Verification
REQ-030 AND gate as DUT, expect_tt=4'b1000, HOLD_CYCLES=10, start pulse -> a/b sequence 00,10,01,11 each held 10 cycles, no mismatch, done at cycle 45, pass=1, err_count=0.
REQ-031 AND gate as DUT, expect_tt=4'b1110 (OR table) -> mismatch pulses at idx 1 and 2, done, err_count=2, pass=0.
REQ-032 dut_out tied to 1, expect_tt=4'b0000 -> four mismatch pulses, err_count=4 (saturated, no wrap), pass=0.
REQ-033 start pulsed again during HOLD of idx 2 and during FINISH -> ignored, single done pulse, sweep timing unchanged.
REQ-034 rst asserted asynchronously mid-HOLD of idx 1 -> outputs at reset values before the next clock edge; no done after rst release until a new start.
REQ-035 HOLD_CYCLES=1, expect_tt=4'b1000, AND DUT -> done at cycle 9, pass=1.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - Sweeps all four {b,a} vectors into a 2-input gate and checks each result against a captured truth table.
module truth_table_sequencer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expect_tt,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       mismatch,
    output logic [2:0] err_count,
    output logic       done,
    output logic       pass
);

    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_exp;
    logic [7:0] r_cnt;
    logic [1:0] r_idx;
    logic       r_busy;
    logic       r_mismatch;
    logic [2:0] r_err;
    logic       r_done;
    logic       r_pass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_exp      <= 4'd0;
            r_cnt      <= 8'd0;
            r_idx      <= 2'd0;
            r_busy     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err      <= 3'd0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_mismatch <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_exp   <= expect_tt;
                        r_idx   <= 2'd0;
                        r_err   <= 3'd0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= HOLD_LOAD;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    if (dut_out != r_exp[r_idx]) begin
                        r_mismatch <= 1'b1;
                        if (r_err != 3'd4) begin
                            r_err <= r_err + 3'd1;
                        end
                    end
                    // The last vector stays applied through FINISH.
                    if (r_idx == 2'd3) begin
                        r_state <= FINISH;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_cnt   <= HOLD_LOAD;
                        r_state <= HOLD;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_pass  <= (r_err == 3'd0);
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a         = r_idx[0];
    assign b         = r_idx[1];
    assign vec_idx   = r_idx;
    assign busy      = r_busy;
    assign mismatch  = r_mismatch;
    assign err_count = r_err;
    assign done      = r_done;
    assign pass      = r_pass;

endmodule
